instr_fetch_unit: RTL

Instruction-fetch front end that reads the combinational program ROM: it drives the 6-bit word read address and captures the returned 32-bit instruction. Holds the PC and buffers fetched {PC, instruction} pairs in a small FIFO toward decode, using a valid/ready handshake. Supports a redirect (branch/jump) that flushes the FIFO, and a fetch enable.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_fifo.sv | 63 ++++++
 rtl/instr_fetch_unit.sv | 69 ++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, reset PC, NOP encoding and the fetch-entry layout for the fetch front end.
package instr_fetch_unit_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [DATA_W-1:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO buffering fetched entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = instr_fetch_unit_pkg::ENTRY_W,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_valid
);
    import instr_fetch_unit_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    // Pop only a real entry; push only into space, or into the slot freed by a same-cycle pop.
    assign w_pop  = i_pop & (r_count != '0);
    assign w_push = i_push & ((r_count < CNT_W'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Head is read from storage only, so nothing combinational reaches it from the write side.
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads the combinational ROM and buffers {PC, instruction} toward decode.
module instr_fetch_unit #(
    parameter int ADDR_W = instr_fetch_unit_pkg::ADDR_W,
    parameter int DATA_W = instr_fetch_unit_pkg::DATA_W,
    parameter int DEPTH  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = instr_fetch_unit_pkg::RESET_PC,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] ReadAddress,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              Enable,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectAddr,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutInstruction,
    output logic [ADDR_W-1:0] OutPC,
    output logic [CNT_W-1:0]  Count
);
    import instr_fetch_unit_pkg::*;

    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] r_pc;
    logic              w_pop;
    logic              w_push;
    logic [EW-1:0]     w_push_entry;
    logic [EW-1:0]     w_head_entry;

    // Handshake: an entry transfers to decode on any cycle where OutValid and OutReady are both
    // high; OutValid never depends on OutReady, and OutReady without OutValid does nothing.
    assign w_pop  = OutValid & OutReady;
    assign w_push = Enable & ~Redirect & ((Count < CNT_W'(DEPTH)) | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (Redirect) begin
            r_pc <= RedirectAddr;
        end else if (w_push) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign ReadAddress  = r_pc;
    assign w_push_entry = {r_pc, Instruction};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (Redirect),
        .i_push  (w_push),
        .i_pop   (w_pop & ~Redirect),
        .i_data  (w_push_entry),
        .o_data  (w_head_entry),
        .o_count (Count),
        .o_valid (OutValid)
    );

    assign OutPC          = w_head_entry[EW-1:DATA_W];
    assign OutInstruction = w_head_entry[DATA_W-1:0];

endmodule
